// File: rtl/axi_full_bram_bridge.sv
// AXI4-Full slave to dual-port BRAM bridge: independent write and read burst engines.
// Optional macro AXI_BRIDGE_RANGE_CHECK_EN flags beats beyond the BRAM as SLVERR.
`timescale 1ns/1ps

// state  | meaning
// W_IDLE | waiting for AW, AWREADY high
// W_DATA | accepting write beats, driving BRAM write port
// W_RESP | presenting B response until BREADY
// R_IDLE | waiting for AR, ARREADY high
// R_BURST| issuing BRAM reads under credit control, draining FIFO onto R
module axi_full_bram_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 14,
   parameter int ID_WIDTH       = 1,
   parameter int RD_LATENCY     = 2,
   parameter int RD_FIFO_DEPTH  = 4
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESETN,
   input  logic [ID_WIDTH-1:0]         S_AXI_AWID,
   input  logic [ADDR_WIDTH-1:0]       S_AXI_AWADDR,
   input  logic [7:0]                  S_AXI_AWLEN,
   input  logic [1:0]                  S_AXI_AWBURST,
   input  logic                        S_AXI_AWVALID,
   output logic                        S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]       S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
   input  logic                        S_AXI_WLAST,
   input  logic                        S_AXI_WVALID,
   output logic                        S_AXI_WREADY,
   output logic [ID_WIDTH-1:0]         S_AXI_BID,
   output logic [1:0]                  S_AXI_BRESP,
   output logic                        S_AXI_BVALID,
   input  logic                        S_AXI_BREADY,
   input  logic [ID_WIDTH-1:0]         S_AXI_ARID,
   input  logic [ADDR_WIDTH-1:0]       S_AXI_ARADDR,
   input  logic [7:0]                  S_AXI_ARLEN,
   input  logic [1:0]                  S_AXI_ARBURST,
   input  logic                        S_AXI_ARVALID,
   output logic                        S_AXI_ARREADY,
   output logic [ID_WIDTH-1:0]         S_AXI_RID,
   output logic [DATA_WIDTH-1:0]       S_AXI_RDATA,
   output logic [1:0]                  S_AXI_RRESP,
   output logic                        S_AXI_RLAST,
   output logic                        S_AXI_RVALID,
   input  logic                        S_AXI_RREADY,
   output logic                        wr_en,
   output logic [MEM_ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]       wr_data,
   output logic [DATA_WIDTH/8-1:0]     wr_strb,
   output logic                        rd_en,
   output logic [MEM_ADDR_WIDTH-1:0]   rd_addr,
   input  logic [DATA_WIDTH-1:0]       rd_data
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFFS  = $clog2(BYTES);
   localparam int PW    = $clog2(RD_FIFO_DEPTH);
   localparam int CW    = PW + 1;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_BURST}         r_state_e;

   w_state_e                w_state_q, w_state_d;
   r_state_e                r_state_q, r_state_d;

   logic [ID_WIDTH-1:0]     awid_q, arid_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
   logic [7:0]              awlen_q, arlen_q;
   logic [1:0]              awburst_q, arburst_q;
   logic [7:0]              wcnt_q, rcnt_q;
   logic                    werr_q;
   logic [8:0]              issued_q;
   logic [CW-1:0]           credits_q, count_q;
   logic [RD_LATENCY-1:0]   vld_q, perr_q;
   logic [RD_LATENCY:0]     vld_pipe, perr_pipe;
   logic [PW-1:0]           wptr_q, rptr_q;
   logic [DATA_WIDTH-1:0]   fifo_data_q [RD_FIFO_DEPTH];
   logic                    fifo_err_q  [RD_FIFO_DEPTH];

   logic aw_hs, w_beat, w_last, ar_hs, rd_issue, r_pop, push, w_oor, r_oor;
   logic unused_wlast;

   // WLAST is not used for termination; the beat counter decides.
   assign unused_wlast = S_AXI_WLAST;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [7:0] len,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] inc, mask;
      inc  = a + ADDR_WIDTH'(BYTES);
      mask = (ADDR_WIDTH'(len) << OFFS) | ADDR_WIDTH'(BYTES - 1);
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~mask) | (inc & mask);
         default: return inc;
      endcase
   endfunction

`ifdef AXI_BRIDGE_RANGE_CHECK_EN
   assign w_oor = (awaddr_q >> (MEM_ADDR_WIDTH + OFFS)) != '0;
   assign r_oor = (araddr_q >> (MEM_ADDR_WIDTH + OFFS)) != '0;
`else
   assign w_oor = 1'b0;
   assign r_oor = 1'b0;
`endif

   // ---------------- write engine ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) w_state_q <= W_IDLE;
      else                w_state_q <= w_state_d;
   end

   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (S_AXI_AWVALID) w_state_d = W_DATA;
         W_DATA:  if (w_last)        w_state_d = W_RESP;
         W_RESP:  if (S_AXI_BREADY)  w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      case (w_state_q)
         W_IDLE:  S_AXI_AWREADY = 1'b1;
         W_DATA:  S_AXI_WREADY  = 1'b1;
         W_RESP:  S_AXI_BVALID  = 1'b1;
         default: ;
      endcase
   end

   assign aw_hs  = S_AXI_AWREADY & S_AXI_AWVALID;
   assign w_beat = S_AXI_WREADY & S_AXI_WVALID;
   assign w_last = w_beat & (wcnt_q == awlen_q);

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         awid_q    <= '0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         awburst_q <= '0;
         wcnt_q    <= '0;
         werr_q    <= 1'b0;
      end else if (aw_hs) begin
         awid_q    <= S_AXI_AWID;
         awaddr_q  <= S_AXI_AWADDR;
         awlen_q   <= S_AXI_AWLEN;
         awburst_q <= S_AXI_AWBURST;
         wcnt_q    <= '0;
         werr_q    <= 1'b0;
      end else if (w_beat) begin
         awaddr_q  <= next_addr(awaddr_q, awlen_q, awburst_q);
         wcnt_q    <= wcnt_q + 8'd1;
         werr_q    <= werr_q | w_oor;
      end
   end

   assign wr_en       = w_beat & ~w_oor;
   assign wr_addr     = awaddr_q[OFFS +: MEM_ADDR_WIDTH];
   assign wr_data     = w_beat ? S_AXI_WDATA : '0;
   assign wr_strb     = w_beat ? S_AXI_WSTRB : '0;
   assign S_AXI_BID   = awid_q;
   assign S_AXI_BRESP = {werr_q, 1'b0};

   // ---------------- read engine ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) r_state_q <= R_IDLE;
      else                r_state_q <= r_state_d;
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (S_AXI_ARVALID)         r_state_d = R_BURST;
         R_BURST: if (r_pop && S_AXI_RLAST)  r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      S_AXI_ARREADY = 1'b0;
      rd_issue      = 1'b0;
      case (r_state_q)
         R_IDLE:  S_AXI_ARREADY = 1'b1;
         R_BURST: rd_issue = ({1'b0, arlen_q} >= issued_q) && (credits_q != '0);
         default: ;
      endcase
   end

   assign ar_hs     = S_AXI_ARREADY & S_AXI_ARVALID;
   assign r_pop     = S_AXI_RVALID & S_AXI_RREADY;
   assign rd_en     = rd_issue;
   assign rd_addr   = araddr_q[OFFS +: MEM_ADDR_WIDTH];
   assign vld_pipe  = {vld_q, rd_issue};
   assign perr_pipe = {perr_q, rd_issue & r_oor};
   assign push      = vld_q[RD_LATENCY-1];

   // Credits cover FIFO entries plus reads still in the latency pipe.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arburst_q <= '0;
         issued_q  <= '0;
         rcnt_q    <= '0;
         credits_q <= CW'(RD_FIFO_DEPTH);
         vld_q     <= '0;
         perr_q    <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
      end else begin
         if (ar_hs) begin
            arid_q    <= S_AXI_ARID;
            araddr_q  <= S_AXI_ARADDR;
            arlen_q   <= S_AXI_ARLEN;
            arburst_q <= S_AXI_ARBURST;
            issued_q  <= '0;
            rcnt_q    <= '0;
         end else begin
            if (rd_issue) begin
               araddr_q <= next_addr(araddr_q, arlen_q, arburst_q);
               issued_q <= issued_q + 9'd1;
            end
            if (r_pop) rcnt_q <= rcnt_q + 8'd1;
         end
         credits_q <= credits_q - CW'(rd_issue) + CW'(r_pop);
         vld_q     <= vld_pipe[RD_LATENCY-1:0];
         perr_q    <= perr_pipe[RD_LATENCY-1:0];
         if (push)  wptr_q <= wptr_q + PW'(1);
         if (r_pop) rptr_q <= rptr_q + PW'(1);
         count_q   <= count_q + CW'(push) - CW'(r_pop);
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (push) begin
         fifo_data_q[wptr_q] <= perr_q[RD_LATENCY-1] ? '0 : rd_data;
         fifo_err_q[wptr_q]  <= perr_q[RD_LATENCY-1];
      end
   end

   assign S_AXI_RVALID = (count_q != '0);
   assign S_AXI_RDATA  = S_AXI_RVALID ? fifo_data_q[rptr_q] : '0;
   assign S_AXI_RRESP  = (S_AXI_RVALID && fifo_err_q[rptr_q]) ? 2'b10 : 2'b00;
   assign S_AXI_RLAST  = S_AXI_RVALID && (rcnt_q == arlen_q);
   assign S_AXI_RID    = arid_q;

endmodule

// File: tb/tb_axi_full_bram_bridge.sv
// Directed bench for axi_full_bram_bridge with a BRAM model and negedge monitors.
// Build with AXI_BRIDGE_RANGE_CHECK_EN to exercise the out-of-range responses.
`timescale 1ns/1ps

module tb_axi_full_bram_bridge;

   localparam int DW = 32, AW = 32, IDW = 4, LAT = 2, DEPTH = 4;
`ifdef AXI_BRIDGE_RANGE_CHECK_EN
   localparam int MAW = 4;
`else
   localparam int MAW = 14;
`endif
   localparam int NB = DW / 8;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [IDW-1:0] awid = '0, arid = '0, bid, rid;
   logic [AW-1:0]  awaddr = '0, araddr = '0;
   logic [7:0]     awlen = '0, arlen = '0;
   logic [1:0]     awburst = '0, arburst = '0, bresp, rresp;
   logic           awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
   logic           bvalid, bready = 1'b0, arvalid = 1'b0, arready;
   logic           rlast, rvalid, rready = 1'b0;
   logic [DW-1:0]  wdata = '0, rdata;
   logic [NB-1:0]  wstrb = '0;
   logic           wr_en, rd_en;
   logic [MAW-1:0] wr_addr, rd_addr;
   logic [DW-1:0]  wr_data, rd_data;
   logic [NB-1:0]  wr_strb;

   int n_checks = 0, n_errors = 0;

   always #5 clk = ~clk;

   axi_full_bram_bridge #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW), .ID_WIDTH(IDW),
      .RD_LATENCY(LAT), .RD_FIFO_DEPTH(DEPTH)
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
      .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
      .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
      .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   // BRAM model: byte-strobed write, two-stage registered read
   logic [DW-1:0] mem [2**MAW];
   logic [DW-1:0] rd_p0 = '0, rd_p1 = '0;
   assign rd_data = rd_p1;

   initial for (int i = 0; i < 2**MAW; i++) mem[i] = 32'hC000_0000 | i;

   always @(posedge clk) begin
      if (wr_en)
         for (int b = 0; b < NB; b++)
            if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      if (rd_en) rd_p0 <= mem[rd_addr];
      rd_p1 <= rd_p0;
   end

   typedef struct { logic [MAW-1:0] addr; logic [DW-1:0] data; logic [NB-1:0] strb; } wr_t;
   typedef struct { logic [DW-1:0] data; logic last; logic [1:0] resp; logic [IDW-1:0] id; } r_t;
   wr_t            wr_q[$];
   logic [MAW-1:0] iss_q[$];
   r_t             r_q[$];
   wr_t            mon_w;
   r_t             mon_r;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) begin
            mon_w.addr = wr_addr; mon_w.data = wr_data; mon_w.strb = wr_strb;
            wr_q.push_back(mon_w);
         end
         if (rd_en) iss_q.push_back(rd_addr);
         if (rvalid && rready) begin
            mon_r.data = rdata; mon_r.last = rlast; mon_r.resp = rresp; mon_r.id = rid;
            r_q.push_back(mon_r);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [DW-1:0] d0, input logic [NB-1:0] strb,
                           output logic [IDW-1:0] b_id, output logic [1:0] b_resp,
                           output int wcyc);
      logic ok;
      awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin ok = awready; tick(); end
      awvalid = 1'b0;
      chk("aw_hs", ok, 1);
      wcyc = 0;
      for (int i = 0; i <= int'(len); i++) begin
         wdata = d0 + DW'(i); wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
         ok = 1'b0;
         for (int c = 0; c < 50 && !ok; c++) begin ok = wready; tick(); wcyc++; end
         if (!ok) chk("w_hs", ok, 1);
      end
      wvalid = 1'b0; wlast = 1'b0;
      bready = 1'b1; ok = 1'b0; b_id = '0; b_resp = 2'b11;
      for (int c = 0; c < 50 && !ok; c++) begin
         ok = bvalid;
         if (ok) begin b_id = bid; b_resp = bresp; end
         tick();
      end
      bready = 1'b0;
      chk("b_hs", ok, 1);
   endtask

   task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input int hold, output int n_iss_hold);
      logic ok;
      r_q.delete(); iss_q.delete();
      arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin ok = arready; tick(); end
      arvalid = 1'b0;
      chk("ar_hs", ok, 1);
      repeat (hold) tick();
      n_iss_hold = iss_q.size();
      rready = 1'b1;
      for (int c = 0; c < 600 && r_q.size() < int'(len) + 1; c++) tick();
      rready = 1'b0;
      chk("r_count", r_q.size(), int'(len) + 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [IDW-1:0] t_bid;
      logic [1:0]     t_bresp;
      int             wcyc, niss;
      int             wrap_w[4];
      wrap_w = '{14, 15, 12, 13};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_awready", awready, 1);
      chk("rst_arready", arready, 1);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_en", rd_en, 0);
      tick();

`ifdef AXI_BRIDGE_RANGE_CHECK_EN
      wr_q.delete();
      do_write(4'h5, 32'h3C, 8'd1, 2'b01, 32'hA0, 4'hF, t_bid, t_bresp, wcyc);
      chk("rc_wr_count", wr_q.size(), 1);
      chk("rc_wr_addr", wr_q[0].addr, 15);
      chk("rc_bresp", t_bresp, 2'b10);
      chk("rc_bid", t_bid, 4'h5);
      do_read(4'h2, 32'h40, 8'd0, 2'b01, 0, niss);
      chk("rc_rresp", r_q[0].resp, 2'b10);
      chk("rc_rdata", r_q[0].data, 0);
      chk("rc_rlast", r_q[0].last, 1);
      do_read(4'h2, 32'h3C, 8'd0, 2'b01, 0, niss);
      chk("rc_in_rresp", r_q[0].resp, 2'b00);
      chk("rc_in_rdata", r_q[0].data, 32'hA0);
`else
      // INCR write of four beats at word 16
      wr_q.delete();
      do_write(4'h5, 32'h40, 8'd3, 2'b01, 32'hA0, 4'hF, t_bid, t_bresp, wcyc);
      chk("incr_wr_count", wr_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("incr_wr_addr", wr_q[i].addr, 16 + i);
         chk("incr_wr_data", wr_q[i].data, 32'hA0 + i);
         chk("incr_wr_strb", wr_q[i].strb, 4'hF);
      end
      chk("incr_bid", t_bid, 4'h5);
      chk("incr_bresp", t_bresp, 2'b00);
      chk("incr_wcyc", wcyc, 4);

      do_read(4'h2, 32'h40, 8'd3, 2'b01, 0, niss);
      for (int i = 0; i < 4; i++) begin
         chk("rb_data", r_q[i].data, 32'hA0 + i);
         chk("rb_last", r_q[i].last, i == 3);
         chk("rb_id", r_q[i].id, 4'h2);
         chk("rb_resp", r_q[i].resp, 2'b00);
      end

      do_read(4'h3, 32'h38, 8'd3, 2'b10, 0, niss);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_addr", iss_q[i], wrap_w[i]);
         chk("wrap_data", r_q[i].data, 32'hC000_0000 | wrap_w[i]);
         chk("wrap_last", r_q[i].last, i == 3);
         chk("wrap_id", r_q[i].id, 4'h3);
      end

      // single-beat partial-strobe write, then single-beat read
      wr_q.delete();
      do_write(4'hA, 32'h100, 8'd0, 2'b00, 32'h1234_5678, 4'h3, t_bid, t_bresp, wcyc);
      chk("len0_wr_count", wr_q.size(), 1);
      chk("len0_wr_strb", wr_q[0].strb, 4'h3);
      chk("len0_bid", t_bid, 4'hA);
      do_read(4'h1, 32'h100, 8'd0, 2'b01, 0, niss);
      chk("len0_rdata", r_q[0].data, 32'hC000_5678);
      chk("len0_rlast", r_q[0].last, 1);

      do_read(4'h4, 32'h44, 8'd2, 2'b00, 0, niss);
      for (int i = 0; i < 3; i++) begin
         chk("fixed_addr", iss_q[i], 17);
         chk("fixed_data", r_q[i].data, 32'hA1);
      end

      // RREADY held low: credits limit outstanding issues to the FIFO depth
      do_read(4'h7, 32'h200, 8'd15, 2'b01, 10, niss);
      chk("bp_issues_held", niss, DEPTH);
      for (int i = 0; i < 16; i++) begin
         chk("bp_addr", iss_q[i], 128 + i);
         chk("bp_data", r_q[i].data, 32'hC000_0080 + i);
         chk("bp_last", r_q[i].last, i == 15);
      end

      wr_q.delete();
      fork
         do_write(4'h6, 32'h400, 8'd7, 2'b01, 32'hB0, 4'hF, t_bid, t_bresp, wcyc);
         do_read(4'h9, 32'h800, 8'd7, 2'b01, 0, niss);
      join
      chk("cc_wcyc", wcyc, 8);
      chk("cc_bid", t_bid, 4'h6);
      chk("cc_bresp", t_bresp, 2'b00);
      for (int i = 0; i < 8; i++) begin
         chk("cc_wr_addr", wr_q[i].addr, 256 + i);
         chk("cc_rdata", r_q[i].data, 32'hC000_0200 + i);
         chk("cc_rid", r_q[i].id, 4'h9);
      end

      // upper address bits beyond the BRAM are dropped silently
      do_read(4'h1, 32'h1_0040, 8'd0, 2'b01, 0, niss);
      chk("trunc_rdata", r_q[0].data, 32'hA0);
      chk("trunc_rresp", r_q[0].resp, 2'b00);

      // reset in the middle of a read burst
      arid = 4'h1; araddr = 32'h300; arlen = 8'd15; arburst = 2'b01; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_rvalid", rvalid, 0);
      chk("mid_rst_arready", arready, 1);
      chk("mid_rst_rd_en", rd_en, 0);
      tick(); tick(); tick();
      chk("mid_rst_discard", rvalid, 0);
      do_read(4'h2, 32'h40, 8'd0, 2'b01, 0, niss);
      chk("post_rst_rdata", r_q[0].data, 32'hA0);
`endif

      chk("end_awready", awready, 1);
      chk("end_arready", arready, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
